falafel_mem_responder: RTL and testbench
========================================

Name: falafel_mem_responder

Overview:
- Memory-side responder for the falafel allocator memory port: accepts read, write and CAS requests and serves them from an internal word array.
- Returns exactly one in-order response per request after a fixed pipeline latency, buffered in a response FIFO under credit-based flow control.
- Used as the memory model behind the falafel wrapper in simulation, and as an on-chip heap-metadata scratchpad on FPGA.

Parameters:
- DEPTH, 1024, number of DATA_W-bit words in the array (power of 2).
- LATENCY, 2, cycles from request acceptance to earliest response valid (>=1).
- RSP_FIFO_DEPTH, 4, response FIFO entries; also the maximum outstanding requests.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- mem_req_val_i  in  1  request valid.
- mem_req_rdy_o  out  1  responder can accept a request.
- mem_req_is_write_i  in  1  1 = write or CAS, 0 = read.
- mem_req_is_cas_i  in  1  1 = CAS; only meaningful when is_write = 1.
- mem_req_addr_i  in  DATA_W  byte address, 8-byte aligned.
- mem_req_data_i  in  DATA_W  write data / CAS new value.
- mem_req_cas_exp_i  in  DATA_W  CAS expected value.
- mem_rsp_val_o  out  1  response valid.
- mem_rsp_rdy_i  in  1  consumer ready.
- mem_rsp_data_o  out  DATA_W  response data.
- err_o  out  1  sticky flag: out-of-range or misaligned access seen.

Behaviour:
- Reset (rst_ni = 0 at a clock edge):
  - mem_req_rdy_o = 0, mem_rsp_val_o = 0, mem_rsp_data_o = 0, err_o = 0.
  - Pipeline, FIFO and credit counter are cleared.
  - Array contents are not reset.
  - Reset asserted mid-operation discards every in-flight response.
- Handshakes:
  - A request is accepted on a cycle where mem_req_val_i && mem_req_rdy_o.
  - A response is consumed on a cycle where mem_rsp_val_o && mem_rsp_rdy_i.
- Credit counter:
  - outstanding = requests in the latency pipe + entries in the FIFO.
  - mem_req_rdy_o = (outstanding < RSP_FIFO_DEPTH), driven only from registered state.
  - Accept and consume in the same cycle leave outstanding unchanged.
- Addressing:
  - Word index = addr[3 +: $clog2(DEPTH)].
  - Out of range means addr[DATA_W-1:3] >= DEPTH. Misaligned means addr[2:0] != 0.
  - Either case: response data 0, no array write, err_o set until reset.
- Operations take effect in the acceptance cycle; the next accepted request sees the result.
  - Read: rsp = mem[idx].
  - Write: mem[idx] <= data; rsp = data.
  - CAS: rsp = old value mem[idx]. If old == cas_exp, mem[idx] <= data. The requester detects success by comparing rsp with exp.
  - is_cas = 1 with is_write = 0 is treated as a read.
- Latency:
  - Response data enters a LATENCY-stage valid/data shift register, then the FIFO.
  - Accept at cycle t gives mem_rsp_val_o = 1 at cycle t+LATENCY at the earliest, when the FIFO is empty.
  - With mem_rsp_rdy_i held high, throughput is 1 request per cycle.
- Boundary behaviour:
  - FIFO never overflows, guaranteed by credits.
  - FIFO empty with a pipe output arriving: the entry appears on the following cycle. No combinational bypass.
  - mem_rsp_data_o is held stable while valid && !rdy.
- Ordering is strictly in acceptance order.

Optional Feature:
- Macro: FALAFEL_MEM_RSP_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle after reset.
  - mem_req_rdy_o is additionally forced 0 on cycles where lfsr[1:0] == 2'b00, giving about 25% random backpressure for handshake stress.
- When undefined: no LFSR; rdy follows credits only.

Decomposition:
- Shared package falafel_pkg:
  - DATA_W.
  - WORD_ADDR_LSB = 3.
  - mem_req_t struct {is_write, is_cas, addr, data, cas_exp}.
  - LFSR seed constant.
- Response buffer: reuse falafel_fifo (DATA_W, RSP_FIFO_DEPTH).
- Latency shift register and array stay inline. No new sub-module.

Test Plan:
- Write addr 0x10 data 0xDEAD, then read 0x10 -> write rsp 0xDEAD; read rsp 0xDEAD, valid exactly LATENCY cycles after acceptance.
- mem[0x18] = 5:
  - CAS exp 5 new 9 -> rsp 5, subsequent read 9.
  - CAS exp 5 new 7 -> rsp 9, mem stays 9.
- Hold mem_rsp_rdy_i = 0 and issue 6 reads -> exactly 4 accepted, rdy_o low.
- Release rdy -> 4 responses in order, data stable while stalled, then rdy_o high.
- Read addr DEPTH*8 and read addr 0x13 -> rsp 0 each, err_o = 1 and sticky, array unchanged.
- Assert rst_ni = 0 with 3 requests outstanding -> next cycle val_o = 0, rdy_o = 0. After release rdy_o = 1 and no stale responses appear.

Source files
------------

// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator memory port.
package falafel_pkg;

   localparam int          DATA_W        = 64;
   localparam int          WORD_ADDR_LSB = 3;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;

   typedef struct packed {
      logic              is_write;
      logic              is_cas;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] cas_exp;
   } mem_req_t;

   // Misaligned or beyond the last word of a depth-word array.
   function automatic logic addr_is_bad(logic [DATA_W-1:0] addr, int unsigned depth);
      return (addr[WORD_ADDR_LSB-1:0] != '0) ||
             ((addr >> WORD_ADDR_LSB) >= DATA_W'(depth));
   endfunction

endpackage

// File: rtl/falafel_mem_responder_if.sv
// Request/response channel of the falafel allocator memory port.
interface falafel_mem_responder_if;
   import falafel_pkg::*;

   logic              mem_req_val_i;
   logic              mem_req_rdy_o;
   logic              mem_req_is_write_i;
   logic              mem_req_is_cas_i;
   logic [DATA_W-1:0] mem_req_addr_i;
   logic [DATA_W-1:0] mem_req_data_i;
   logic [DATA_W-1:0] mem_req_cas_exp_i;
   logic              mem_rsp_val_o;
   logic              mem_rsp_rdy_i;
   logic [DATA_W-1:0] mem_rsp_data_o;

   modport master (
      output mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
             mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i, mem_rsp_rdy_i,
      input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
   );

   modport slave (
      input  mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
             mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i, mem_rsp_rdy_i,
      output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
   );

endinterface

// File: rtl/falafel_fifo.sv
// Synchronous FIFO shared across falafel blocks; only pointers and occupancy are reset.
module falafel_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             full, do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (!do_push && do_pop) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/falafel_mem_responder.sv
// Memory-side responder: read/write/CAS on a word array with in-order responses after LATENCY
// cycles. Define FALAFEL_MEM_RSP_STALL_EN for LFSR-driven random request backpressure.
module falafel_mem_responder
   import falafel_pkg::*;
#(
   parameter int DEPTH          = 1024,
   parameter int LATENCY        = 2,
   parameter int RSP_FIFO_DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   falafel_mem_responder_if.slave bus,
   output logic                   err_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

   mem_req_t          req;
   logic              acc, pop, bad, cas_hit, wr_en, gate;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;
   logic              vld_p0;
   logic [DATA_W-1:0] dat_p0;
   logic              push_vld;
   logic [DATA_W-1:0] push_dat;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic              credit_q;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_comb begin
      req.is_write = bus.mem_req_is_write_i;
      req.is_cas   = bus.mem_req_is_cas_i;
      req.addr     = bus.mem_req_addr_i;
      req.data     = bus.mem_req_data_i;
      req.cas_exp  = bus.mem_req_cas_exp_i;
   end

   assign bus.mem_req_rdy_o = credit_q && gate;
   assign acc     = bus.mem_req_val_i && bus.mem_req_rdy_o;
   assign pop     = bus.mem_rsp_val_o && bus.mem_rsp_rdy_i;
   assign idx     = req.addr[WORD_ADDR_LSB +: IDX_W];
   assign bad     = addr_is_bad(req.addr, DEPTH);
   assign rd_word = mem_q[idx];
   assign cas_hit = (rd_word == req.cas_exp);

   // Stage p0: the access resolves in the acceptance cycle so the next request sees it
   always_comb begin
      wr_en  = 1'b0;
      dat_p0 = rd_word;
      if (bad) begin
         dat_p0 = '0;
      end else if (req.is_write) begin
         if (req.is_cas) begin
            wr_en = cas_hit;
         end else begin
            wr_en  = 1'b1;
            dat_p0 = req.data;
         end
      end
   end
   assign vld_p0 = acc;

   always_ff @(posedge clk_i) begin
      if (acc && wr_en) mem_q[idx] <= req.data;
   end

   // Stages p1..p(LATENCY-1); the FIFO write is the final stage of the latency
   generate
      if (LATENCY == 1) begin : g_no_pipe
         assign push_vld = vld_p0;
         assign push_dat = dat_p0;
      end else begin : g_pipe
         logic              vld_pn [LATENCY-1];
         logic [DATA_W-1:0] dat_pn [LATENCY-1];

         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               for (int i = 0; i < LATENCY - 1; i++) vld_pn[i] <= 1'b0;
            end else begin
               vld_pn[0] <= vld_p0;
               for (int i = 1; i < LATENCY - 1; i++) vld_pn[i] <= vld_pn[i-1];
            end
         end

         always_ff @(posedge clk_i) begin
            dat_pn[0] <= dat_p0;
            for (int i = 1; i < LATENCY - 1; i++) dat_pn[i] <= dat_pn[i-1];
         end

         assign push_vld = vld_pn[LATENCY-2];
         assign push_dat = dat_pn[LATENCY-2];
      end
   endgenerate

   falafel_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RSP_FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_vld),
      .data_i  (push_dat),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .empty_o (fifo_empty)
   );

   assign bus.mem_rsp_val_o  = !fifo_empty;
   assign bus.mem_rsp_data_o = fifo_empty ? '0 : fifo_data;

   // Credits cover pipe plus FIFO, so the FIFO cannot overflow
   always_comb begin
      cnt_n = cnt_q;
      if (acc && !pop)      cnt_n = cnt_q + CNT_W'(1);
      else if (!acc && pop) cnt_n = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         credit_q <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         cnt_q    <= cnt_n;
         credit_q <= (cnt_n < CNT_W'(RSP_FIFO_DEPTH));
         if (acc && bad) err_o <= 1'b1;
      end
   end

`ifdef FALAFEL_MEM_RSP_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign gate = (lfsr_q[1:0] != 2'b00);
`else
   assign gate = 1'b1;
`endif

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed and randomized bench for falafel_mem_responder against a transaction-level
// memory model with an in-order expected-response queue.
module tb_falafel_mem_responder;
   import falafel_pkg::*;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;
   localparam int FDEPTH  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic err;

   falafel_mem_responder_if bus();

   falafel_mem_responder #(
      .DEPTH          (DEPTH),
      .LATENCY        (LATENCY),
      .RSP_FIFO_DEPTH (FDEPTH)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .err_o  (err)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int passed  = 0;
   int fails   = 0;
   int pops    = 0;
   int accepts = 0;
   bit m_err   = 1'b0;
   bit chk_rdy = 1'b0;
   logic [DATA_W-1:0] mm [int];
   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] last_rsp = '0;

   task automatic chk(string tag, logic [DATA_W-1:0] obs, logic [DATA_W-1:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Memory semantics applied at acceptance: returns the response word.
   function automatic logic [DATA_W-1:0] model(bit w, bit c, logic [DATA_W-1:0] a,
                                              logic [DATA_W-1:0] d, logic [DATA_W-1:0] e);
      logic [DATA_W-1:0] old;
      int i;
      if ((a % 8) != 0 || (a / 8) >= DEPTH) begin
         m_err = 1'b1;
         return '0;
      end
      i   = int'(a / 8);
      old = mm[i];
      if (!w) return old;
      if (!c) begin
         mm[i] = d;
         return d;
      end
      if (old == e) mm[i] = d;
      return old;
   endfunction

   task automatic step();
      if (chk_rdy) chk("rdy_credit", 64'(bus.mem_req_rdy_o), 64'(exp_q.size() < FDEPTH));
      if (bus.mem_rsp_val_o && bus.mem_rsp_rdy_i) begin
         pops++;
         last_rsp = bus.mem_rsp_data_o;
         chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("rsp_data", bus.mem_rsp_data_o, exp_q.pop_front());
      end
      if (bus.mem_req_val_i && bus.mem_req_rdy_o) begin
         accepts++;
         exp_q.push_back(model(bus.mem_req_is_write_i, bus.mem_req_is_cas_i, bus.mem_req_addr_i,
                               bus.mem_req_data_i, bus.mem_req_cas_exp_i));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(bit w, bit c, logic [DATA_W-1:0] a, logic [DATA_W-1:0] d,
                       logic [DATA_W-1:0] e);
      int n;
      bus.mem_req_is_write_i = w;
      bus.mem_req_is_cas_i   = c;
      bus.mem_req_addr_i     = a;
      bus.mem_req_data_i     = d;
      bus.mem_req_cas_exp_i  = e;
      bus.mem_req_val_i      = 1'b1;
      n = 0;
      while (!bus.mem_req_rdy_o && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
      step();
      bus.mem_req_val_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic lat_check(string tag);
      for (int k = 1; k < LATENCY; k++) begin
         chk({tag, "_early"}, 64'(bus.mem_rsp_val_o), 64'd0);
         step();
      end
      chk({tag, "_valid"}, 64'(bus.mem_rsp_val_o), 64'd1);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned op;
      logic [DATA_W-1:0] a, d0;
      int a0, p0;

      bus.mem_req_val_i      = 1'b0;
      bus.mem_req_is_write_i = 1'b0;
      bus.mem_req_is_cas_i   = 1'b0;
      bus.mem_req_addr_i     = '0;
      bus.mem_req_data_i     = '0;
      bus.mem_req_cas_exp_i  = '0;
      bus.mem_rsp_rdy_i      = 1'b1;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rdy", 64'(bus.mem_req_rdy_o), 64'd0);
      chk("reset_val", 64'(bus.mem_rsp_val_o), 64'd0);
      chk("reset_data", bus.mem_rsp_data_o, 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      step();
      chk("rdy_after_reset", 64'(bus.mem_req_rdy_o), 64'd1);

      // write then read with exact latency
      send(1'b1, 1'b0, 64'h10, 64'hDEAD, 64'd0);
      lat_check("wr_lat");
      chk("wr_rsp", last_rsp, 64'hDEAD);
      send(1'b0, 1'b0, 64'h10, 64'd0, 64'd0);
      lat_check("rd_lat");
      chk("rd_rsp", last_rsp, 64'hDEAD);

      // CAS hit, miss, and CAS-without-write as a read
      send(1'b1, 1'b0, 64'h18, 64'd5, 64'd0);  drain();
      send(1'b1, 1'b1, 64'h18, 64'd9, 64'd5);  drain();
      chk("cas_hit_old", last_rsp, 64'd5);
      send(1'b0, 1'b0, 64'h18, 64'd0, 64'd0);  drain();
      chk("cas_hit_read", last_rsp, 64'd9);
      send(1'b1, 1'b1, 64'h18, 64'd7, 64'd5);  drain();
      chk("cas_miss_old", last_rsp, 64'd9);
      send(1'b0, 1'b1, 64'h18, 64'd3, 64'd9);  drain();
      chk("cas_nowrite_rsp", last_rsp, 64'd9);
      send(1'b0, 1'b0, 64'h18, 64'd0, 64'd0);  drain();
      chk("cas_miss_read", last_rsp, 64'd9);

      // out-of-range and misaligned accesses
      chk("err_clear", 64'(err), 64'd0);
      send(1'b0, 1'b0, 64'(DEPTH * 8), 64'd0, 64'd0);  drain();
      chk("oor_rsp", last_rsp, 64'd0);
      chk("err_set", 64'(err), 64'd1);
      send(1'b0, 1'b0, 64'h13, 64'd0, 64'd0);  drain();
      chk("mis_rsp", last_rsp, 64'd0);
      send(1'b1, 1'b0, 64'(DEPTH * 8 + 'h10), 64'hBAD, 64'd0);  drain();
      chk("oor_wr_rsp", last_rsp, 64'd0);
      send(1'b1, 1'b0, 64'h11, 64'hBAD, 64'd0);  drain();
      send(1'b0, 1'b0, 64'h10, 64'd0, 64'd0);  drain();
      chk("array_unchanged", last_rsp, 64'hDEAD);
      chk("err_sticky", 64'(err), 64'd1);
      chk("err_model", 64'(err), 64'(m_err));

      // initialise words 0..7, then randomized traffic with random consumer stalls
      for (int i = 0; i < 8; i++) begin
         send(1'b1, 1'b0, 64'(i * 8), {$urandom, $urandom}, 64'd0);
      end
      drain();
      chk_rdy = 1'b1;
      for (int k = 0; k < 300; k++) begin
         op = $urandom_range(0, 3);
         a  = 64'($urandom_range(0, 7)) << 3;
         bus.mem_rsp_rdy_i      = ($urandom_range(0, 3) != 0);
         bus.mem_req_val_i      = ($urandom_range(0, 1) != 0);
         bus.mem_req_addr_i     = a;
         bus.mem_req_is_write_i = (op == 1 || op == 2);
         bus.mem_req_is_cas_i   = (op == 2 || op == 3);
         bus.mem_req_data_i     = {$urandom, $urandom};
         bus.mem_req_cas_exp_i  = ($urandom_range(0, 1) != 0) ? mm[int'(a >> 3)] : {$urandom, $urandom};
         step();
      end
      bus.mem_req_val_i = 1'b0;
      bus.mem_rsp_rdy_i = 1'b1;
      drain();

      // full throughput with the consumer always ready
      a0 = accepts;
      bus.mem_req_is_write_i = 1'b0;
      bus.mem_req_is_cas_i   = 1'b0;
      bus.mem_req_val_i      = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.mem_req_addr_i = 64'(k % 8) << 3;
         step();
      end
      bus.mem_req_val_i = 1'b0;
      chk("throughput", 64'(accepts - a0), 64'd8);
      drain();
      chk_rdy = 1'b0;

      // backpressure: 6 reads offered, only FDEPTH accepted
      bus.mem_rsp_rdy_i = 1'b0;
      bus.mem_req_val_i = 1'b1;
      a0 = accepts;
      for (int k = 0; k < 10; k++) begin
         bus.mem_req_addr_i = 64'((accepts - a0) % 6) << 3;
         step();
      end
      bus.mem_req_val_i = 1'b0;
      chk("bp_accepted", 64'(accepts - a0), 64'(FDEPTH));
      chk("bp_rdy_low", 64'(bus.mem_req_rdy_o), 64'd0);
      chk("bp_val", 64'(bus.mem_rsp_val_o), 64'd1);
      d0 = bus.mem_rsp_data_o;
      chk("bp_head", d0, exp_q[0]);
      step();
      step();
      chk("bp_stable", bus.mem_rsp_data_o, d0);
      chk("bp_val_held", 64'(bus.mem_rsp_val_o), 64'd1);
      p0 = pops;
      bus.mem_rsp_rdy_i = 1'b1;
      drain();
      chk("bp_released", 64'(pops - p0), 64'(FDEPTH));
      chk("rdy_recovered", 64'(bus.mem_req_rdy_o), 64'd1);

      // reset with responses in flight
      bus.mem_rsp_rdy_i = 1'b0;
      send(1'b0, 1'b0, 64'h10, 64'd0, 64'd0);
      send(1'b0, 1'b0, 64'h18, 64'd0, 64'd0);
      send(1'b0, 1'b0, 64'h20, 64'd0, 64'd0);
      rst_n = 1'b0;
      step();
      exp_q.delete();
      m_err = 1'b0;
      chk("rst_mid_val", 64'(bus.mem_rsp_val_o), 64'd0);
      chk("rst_mid_rdy", 64'(bus.mem_req_rdy_o), 64'd0);
      chk("rst_mid_data", bus.mem_rsp_data_o, 64'd0);
      chk("rst_mid_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      step();
      chk("rst_rel_rdy", 64'(bus.mem_req_rdy_o), 64'd1);
      bus.mem_rsp_rdy_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("no_stale", 64'(bus.mem_rsp_val_o), 64'd0);
         step();
      end
      send(1'b0, 1'b0, 64'h10, 64'd0, 64'd0);
      drain();
      chk("array_kept", last_rsp, mm[2]);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
